// File: rtl/display_scan_ctrl.sv
// Scan sequencer for an 8-digit seven-segment display: select, active-low anodes, blanking gap, frame pulse.
// All outputs are registered; masked digits are skipped; enable=0 or an empty mask parks the scan dark in IDLE.
module display_scan_ctrl #(
   parameter int SHOW_CYCLES  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [7:0] digit_mask,
   output logic [2:0] select,
   output logic [7:0] digit_en_n,
   output logic       blank,
   output logic       frame_tick
);

   localparam int CMAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
   localparam int CW   = $clog2(CMAX) + 1;
   localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   state_t          r_state, w_nstate;
   logic [CW-1:0]   r_cnt, w_ncnt;
   logic [2:0]      r_sel, w_nsel, w_first, w_next;
   logic            w_ntick;
   logic [7:0]      r_den_n;
   logic            r_blank, r_tick;

   // Loops run downward so the last hit, i.e. the nearest candidate, wins.
   always_comb begin
      w_first = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (digit_mask[i]) w_first = 3'(i);
      end
      w_next = r_sel;
      for (int k = 8; k >= 1; k--) begin
         if (digit_mask[r_sel + 3'(k)]) w_next = r_sel + 3'(k);
      end
   end

   always_comb begin
      w_nstate = r_state;
      w_ncnt   = r_cnt + 1'b1;
      w_nsel   = r_sel;
      w_ntick  = 1'b0;
      if (!enable) begin
         w_nstate = IDLE;
         w_ncnt   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               w_ncnt = '0;
               if (digit_mask != 8'h00) begin
                  w_nstate = BLANK;
                  w_nsel   = w_first;
               end
            end
            BLANK: begin
               if (r_cnt == BLANK_LAST) begin
                  w_nstate = SHOW;
                  w_ncnt   = '0;
               end
            end
            SHOW: begin
               if (r_cnt == SHOW_LAST) begin
                  w_ncnt = '0;
                  if (digit_mask == 8'h00) begin
                     w_nstate = IDLE;
                  end else begin
                     w_nstate = BLANK;
                     w_nsel   = w_next;
                     w_ntick  = (w_next <= r_sel);
                  end
               end
            end
            default: begin
               w_nstate = IDLE;
               w_ncnt   = '0;
            end
         endcase
      end
   end

   // Anode enables are derived from the next state so they line up with select.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_sel   <= 3'd0;
         r_den_n <= 8'hFF;
         r_blank <= 1'b1;
         r_tick  <= 1'b0;
      end else begin
         r_state <= w_nstate;
         r_cnt   <= w_ncnt;
         r_sel   <= w_nsel;
         r_den_n <= (w_nstate == SHOW) ? ~(8'b1 << w_nsel) : 8'hFF;
         r_blank <= (w_nstate != SHOW);
         r_tick  <= w_ntick;
      end
   end

   assign select     = r_sel;
   assign digit_en_n = r_den_n;
   assign blank      = r_blank;
   assign frame_tick = r_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with SHOW_CYCLES=4, BLANK_CYCLES=2.
// A vector table covers the steady scan patterns; hand sequences cover mask-empty, enable drop and async reset.
module tb_display_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic [7:0] digit_mask = 8'h00;
   logic [2:0] select;
   logic [7:0] digit_en_n;
   logic       blank;
   logic       frame_tick;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       en;
      logic [7:0] mask;
      logic [2:0] sel;
      logic [7:0] den;
      logic       blk;
      logic       tick;
   } vec_t;

   vec_t vecs[$];

   display_scan_ctrl #(.SHOW_CYCLES(4), .BLANK_CYCLES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .digit_mask (digit_mask),
      .select     (select),
      .digit_en_n (digit_en_n),
      .blank      (blank),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [2:0] s, input logic [7:0] d,
                        input logic b, input logic t);
      checks++;
      if (select !== s || digit_en_n !== d || blank !== b || frame_tick !== t) begin
         errors++;
         $display("FAIL %s: got sel=%0d en_n=%h blank=%b tick=%b, expected sel=%0d en_n=%h blank=%b tick=%b",
                  name, select, digit_en_n, blank, frame_tick, s, d, b, t);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      enable     = 1'b0;
      digit_mask = 8'h00;
      step();
      check("reset", 3'd0, 8'hFF, 1'b1, 1'b0);
      rst_n = 1'b1;
   endtask

   // One digit slot: two blank clocks then four lit clocks.
   task automatic add_digit(input logic [7:0] m_first, input logic [7:0] m_rest,
                            input logic [2:0] s, input logic t);
      logic [7:0] lit;
      lit = ~(8'b1 << s);
      vecs.push_back('{1'b1, m_first, s, 8'hFF, 1'b1, t});
      vecs.push_back('{1'b1, m_rest,  s, 8'hFF, 1'b1, 1'b0});
      for (int i = 0; i < 4; i++) vecs.push_back('{1'b1, m_rest, s, lit, 1'b0, 1'b0});
   endtask

   // Anodes must be all-off or exactly one-hot, and blank must agree.
   always @(negedge clk) begin
      checks++;
      if ((digit_en_n !== 8'hFF && !$onehot(~digit_en_n)) || (blank !== (digit_en_n == 8'hFF))) begin
         errors++;
         $display("FAIL invariant: en_n=%h blank=%b, required off or one-hot with matching blank",
                  digit_en_n, blank);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, required completion before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      localparam logic [7:0] M2 = 8'b1010_0100;
      localparam logic [7:0] M3 = 8'h08;

      for (int d = 0; d < 8; d++) add_digit(8'hFF, 8'hFF, 3'(d), 1'b0);
      add_digit(8'hFF, M2, 3'd0, 1'b1);
      add_digit(M2, M2, 3'd2, 1'b0);
      add_digit(M2, M2, 3'd5, 1'b0);
      add_digit(M2, M2, 3'd7, 1'b0);
      add_digit(M2, M2, 3'd2, 1'b1);
      add_digit(M2, M2, 3'd5, 1'b0);
      add_digit(M2, M2, 3'd7, 1'b0);
      add_digit(M2, M3, 3'd2, 1'b1);
      add_digit(M3, M3, 3'd3, 1'b0);
      add_digit(M3, M3, 3'd3, 1'b1);
      add_digit(M3, M3, 3'd3, 1'b1);

      do_reset();
      foreach (vecs[i]) begin
         enable     = vecs[i].en;
         digit_mask = vecs[i].mask;
         step();
         check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].den, vecs[i].blk, vecs[i].tick);
      end

      // Mask emptied mid-SHOW of digit 1.
      do_reset();
      enable = 1'b1; digit_mask = 8'hFF;
      for (int i = 0; i < 9; i++) step();
      check("d1_show_first", 3'd1, 8'hFD, 1'b0, 1'b0);
      digit_mask = 8'h00;
      for (int i = 0; i < 3; i++) begin
         step();
         check("d1_show_finish", 3'd1, 8'hFD, 1'b0, 1'b0);
      end
      for (int i = 0; i < 10; i++) begin
         step();
         check("mask_empty_idle", 3'd1, 8'hFF, 1'b1, 1'b0);
      end
      digit_mask = 8'h10;
      step(); check("restore_blank1", 3'd4, 8'hFF, 1'b1, 1'b0);
      step(); check("restore_blank2", 3'd4, 8'hFF, 1'b1, 1'b0);
      step(); check("restore_show4", 3'd4, 8'hEF, 1'b0, 1'b0);

      // Enable dropped during SHOW of digit 5.
      do_reset();
      enable = 1'b1; digit_mask = 8'hFF;
      for (int i = 0; i < 33; i++) step();
      check("d5_show", 3'd5, 8'hDF, 1'b0, 1'b0);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("disabled_idle", 3'd5, 8'hFF, 1'b1, 1'b0);
      end
      enable = 1'b1;
      step(); check("reenable_blank1", 3'd0, 8'hFF, 1'b1, 1'b0);
      step(); check("reenable_blank2", 3'd0, 8'hFF, 1'b1, 1'b0);
      step(); check("reenable_show0", 3'd0, 8'hFE, 1'b0, 1'b0);

      // Asynchronous reset in the middle of digit 2's SHOW.
      do_reset();
      enable = 1'b1; digit_mask = 8'hFF;
      for (int i = 0; i < 16; i++) step();
      check("d2_show", 3'd2, 8'hFB, 1'b0, 1'b0);
      #3 rst_n = 1'b0;
      #1 check("async_reset", 3'd0, 8'hFF, 1'b1, 1'b0);
      #2 rst_n = 1'b1;
      step(); check("post_reset_blank1", 3'd0, 8'hFF, 1'b1, 1'b0);
      step(); check("post_reset_blank2", 3'd0, 8'hFF, 1'b1, 1'b0);
      step(); check("post_reset_show0", 3'd0, 8'hFE, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step();
      step(); check("post_reset_d1_blank", 3'd1, 8'hFF, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
